uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among N byte-stream requesters.
- Each requester has a valid/ready/last interface. Ownership is granted round-robin and held for a whole packet, so packets never interleave on the wire.
- The block sequences the serializer's send/busy handshake. It sits between on-chip message sources (debug console, status reporter, etc.) and the single uart_tx instance.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_BURST, 0, max bytes per grant before forced release; 0 = unlimited (release only on last).
- TIMEOUT, 15, cycles to wait in WAIT_HI for tx_busy to rise before flagging an error (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N  per-requester byte valid.
- req_data  in  8*N  byte for requester i at bits [8i+7:8i].
- req_last  in  N  marks final byte of a packet; sampled with the byte.
- req_ready  out  N  accept strobe; byte i transfers when req_valid[i] && req_ready[i].
- tx_send  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; stable from the pulse until the next acceptance.
- tx_busy  in  1  uart_tx busy.
- grant  out  N  one-hot current owner, registered; all-zero when idle.
- err  out  1  one-cycle pulse on busy-rise timeout.

Behaviour:
- Single clock. Reset is synchronous and active-low (rst_n sampled on posedge clk).
- While rst_n=0:
  - state=IDLE; grant=0; req_ready=0; tx_send=0; tx_data=0; err=0.
  - burst count=0; last_owner=N-1, so requester 0 has first priority.
- FSM states: IDLE, FETCH, PULSE, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req_valid is set, pick the first set index scanning from (last_owner+1) mod N upward with wrap.
  - Register grant, then go to FETCH. Otherwise stay in IDLE.
- FETCH:
  - req_ready[g] = (state==FETCH) && !tx_busy. This is combinational, and all other ready bits are 0.
  - On acceptance: latch tx_data<=byte, latch last flag, increment burst count, go to PULSE.
  - If tx_busy=1 (e.g. a byte still in flight after reset) or valid is low: stay in FETCH and hold grant.
- PULSE: tx_send=1 for exactly this cycle, then go to WAIT_HI.
- WAIT_HI:
  - Wait for tx_busy=1, then go to WAIT_LO.
  - If busy has not risen after TIMEOUT cycles in this state: err=1 for one cycle and go to the release check (the byte is treated as sent).
- WAIT_LO / release check: on tx_busy=0 (or after a timeout):
  - If latched last=1, or MAX_BURST≠0 and burst count==MAX_BURST: release. Set grant=0, last_owner=g, burst count=0, go to IDLE.
  - Otherwise go to FETCH with the same owner.
- Latency:
  - Valid in IDLE at cycle 0 gives grant and ready at cycle 1 (if not busy) and tx_send at cycle 2.
  - Between bytes of one packet there are 2 cycles after busy falls before the next tx_send.
- Requester rules:
  - req_valid/data/last must be held until accepted.
  - A requester dropping valid mid-packet stalls the arbiter in FETCH indefinitely; this is intended packet-integrity behaviour.
- Simultaneous events:
  - Requests arriving while another owner is active wait. Fairness is evaluated only in IDLE.
  - tx_send is never asserted while tx_busy=1.
- Reset mid-operation: all state clears immediately. An in-flight uart byte completes on its own, and the next send waits in FETCH for tx_busy=0.
- Width rules:
  - Burst counter width is clog2(MAX_BURST+1), minimum 1 bit, and saturates.
  - The timeout counter is 8 bits and clears on entry to WAIT_HI.

Test Plan:
Use a uart_tx model with 10 clocks per bit, so busy lasts about 100 cycles per byte.
- Requester 1 sends 0x41,0x42 (last on 0x42) -> tx_send twice with tx_data 0x41 then 0x42; grant=0b0010 throughout, then 0; no err.
- Requesters 0,2,3 each post a 1-byte packet (0x10,0x20,0x30) simultaneously -> wire order 0x10,0x20,0x30. A new req0 arriving during 0x20 is serviced after 0x30 (round-robin wrap).
- Req0 sends a 3-byte packet while req1 is valid from cycle 1 -> all 3 req0 bytes go out before any req1 byte; req_ready[1] stays 0 until grant=0b0010.
- MAX_BURST=2, req0 sends 4 bytes without last, with req1 waiting -> sequence is req0,req0,req1…,req0,req0.
- tx_busy tied 0 -> after tx_send, err pulses once at TIMEOUT+1 cycles; the arbiter releases or continues normally.
- Assert rst_n=0 for 1 cycle during WAIT_LO -> grant=0 next cycle. The next byte's tx_send occurs only after tx_busy falls. The first byte after reset comes from requester 0 when all are valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx send/busy handshake for the shared-serializer arbiter.
// Latency: none, this only bundles wires.
// Backpressure: req_ready per requester; tx_busy from the serializer throttles every send.
interface uart_tx_arbiter_if #(
   parameter int N = 4
);
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_send;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [N-1:0]   grant;
   logic           err;

   // Environment side: requesters and the uart_tx serializer.
   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_send, tx_data, grant, err
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_send, tx_data, grant, err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N requesters; round-robin grant held for a whole packet.
// Latency: valid in IDLE -> grant/ready next cycle -> tx_send the cycle after; next send 2 cycles after busy falls.
// Backpressure: only the owner sees req_ready, and only in FETCH with tx_busy low; a stalled owner keeps the grant.
module uart_tx_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 0,
   parameter int TIMEOUT   = 15
) (
   input logic              clk,
   input logic              rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int         IW = (N > 1) ? $clog2(N) : 1;
   localparam int         BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [7:0] TO = 8'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, FETCH, PULSE, WAIT_HI, WAIT_LO} state_t;

   state_t        state, state_nx;
   logic [N-1:0]  grant_q;
   logic [IW-1:0] gidx;
   logic [IW-1:0] last_owner;
   logic [BW-1:0] bcnt;
   logic [7:0]    tcnt;
   logic [7:0]    tx_data_q;
   logic          last_q;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  pick_oh;
   logic          sel_vld;
   logic          sel_last;
   logic [7:0]    sel_dat;
   logic [N-1:0]  ready_c;
   logic          send_c;
   logic          err_c;
   logic          accept;
   logic          done;
   logic          release_now;

   // Round-robin pick: nearest valid requester after last_owner, distance 1..N with wrap.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_oh    = '0;
      for (int d = 1; d <= N; d++) begin
         for (int j = 0; j < N; j++) begin
            if (!pick_found && bus.req_valid[j] && (((int'(last_owner) + d) % N) == j)) begin
               pick_found = 1'b1;
               pick_idx   = IW'(j);
               pick_oh[j] = 1'b1;
            end
         end
      end
   end

   // Mux the owner's byte stream using the one-hot grant.
   always_comb begin
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      sel_dat  = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            sel_vld  = bus.req_valid[i];
            sel_last = bus.req_last[i];
            sel_dat  = bus.req_data[8*i +: 8];
         end
      end
   end

   // Release after the last byte of a packet, or when the burst limit is reached.
   assign release_now = last_q || ((MAX_BURST != 0) && (int'(bcnt) == MAX_BURST));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and strobes; a timeout falls through to the same release decision as busy falling.
   always_comb begin
      state_nx = state;
      ready_c  = '0;
      send_c   = 1'b0;
      err_c    = 1'b0;
      accept   = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE:    if (pick_found) state_nx = FETCH;
         FETCH: begin
            ready_c = grant_q & {N{!bus.tx_busy}};
            if (sel_vld && !bus.tx_busy) begin
               accept   = 1'b1;
               state_nx = PULSE;
            end
         end
         PULSE: begin
            send_c   = 1'b1;
            state_nx = WAIT_HI;
         end
         WAIT_HI: begin
            if (bus.tx_busy) begin
               state_nx = WAIT_LO;
            end else if (tcnt == TO) begin
               err_c = 1'b1;
               done  = 1'b1;
            end
         end
         WAIT_LO: if (!bus.tx_busy) done = 1'b1;
         default: state_nx = IDLE;
      endcase
      if (done) state_nx = release_now ? IDLE : FETCH;
   end

   // Ownership, byte latch, burst and busy-rise counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q    <= '0;
         gidx       <= '0;
         last_owner <= IW'(N - 1);
         bcnt       <= '0;
         tcnt       <= '0;
         tx_data_q  <= '0;
         last_q     <= 1'b0;
      end else begin
         if (state == IDLE && pick_found) begin
            grant_q <= pick_oh;
            gidx    <= pick_idx;
         end
         if (accept) begin
            tx_data_q <= sel_dat;
            last_q    <= sel_last;
            if (bcnt != {BW{1'b1}}) bcnt <= bcnt + 1'b1;
         end
         if (state == PULSE) tcnt <= '0;
         else if (state == WAIT_HI && tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
         if (done && release_now) begin
            grant_q    <= '0;
            last_owner <= gidx;
            bcnt       <= '0;
         end
      end
   end

   assign bus.req_ready = rst_n ? ready_c : '0;
   assign bus.tx_send   = rst_n & send_c;
   assign bus.err       = rst_n & err_c;
   assign bus.tx_data   = tx_data_q;
   assign bus.grant     = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (unlimited burst, burst of 2) each driving a 100-cycle-per-byte uart model.
// Latency: n/a.
// Backpressure: requester queues only advance on valid && ready.
module tb_uart_tx_arbiter;
   localparam int N = 4;

   typedef struct packed {logic [1:0] id; logic last; logic [7:0] dat;} item_t;
   typedef struct packed {logic [3:0] g; logic [7:0] d; logic [31:0] c;} sent_t;

   logic  clk = 1'b0;
   logic  rst_n_a, rst_n_b;
   int    cyc = 0;
   int    compared = 0;
   int    mismatched = 0;
   int    send_busy_viol = 0;
   int    rdy_viol = 0;
   item_t qa[$];
   item_t qb[$];
   sent_t la[$];
   sent_t lb[$];
   sent_t tmp_a, tmp_b;
   int    err_a[$];
   int    err_b[$];
   int    fall_a[$];
   int    bc_a = 0;
   int    bc_b = 0;
   logic  busy_en_a = 1'b1;

   uart_tx_arbiter_if #(.N(N)) ia ();
   uart_tx_arbiter_if #(.N(N)) ib ();

   uart_tx_arbiter #(.N(N), .MAX_BURST(0), .TIMEOUT(15)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ia.slave));
   uart_tx_arbiter #(.N(N), .MAX_BURST(2), .TIMEOUT(15)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ib.slave));

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart models: busy for 100 cycles after each send; log every send with owner and cycle.
   assign ia.tx_busy = (bc_a != 0);
   assign ib.tx_busy = (bc_b != 0);

   always @(posedge clk) begin
      if (ia.tx_send) begin
         if (ia.tx_busy) send_busy_viol++;
         tmp_a.g = ia.grant; tmp_a.d = ia.tx_data; tmp_a.c = 32'(cyc);
         la.push_back(tmp_a);
      end
      if (ia.err) err_a.push_back(cyc);
      if (ia.tx_send && busy_en_a) bc_a <= 100;
      else if (bc_a != 0) begin
         if (bc_a == 1) fall_a.push_back(cyc);
         bc_a <= bc_a - 1;
      end
   end

   always @(posedge clk) begin
      if (ib.tx_send) begin
         if (ib.tx_busy) send_busy_viol++;
         tmp_b.g = ib.grant; tmp_b.d = ib.tx_data; tmp_b.c = 32'(cyc);
         lb.push_back(tmp_b);
      end
      if (ib.err) err_b.push_back(cyc);
      if (ib.tx_send) bc_b <= 100;
      else if (bc_b != 0) bc_b <= bc_b - 1;
   end

   // Ready must never be offered to a requester that does not own the serializer.
   always @(negedge clk) begin
      if ((ia.req_ready & ~ia.grant) != 4'b0) rdy_viol++;
      if ((ib.req_ready & ~ib.grant) != 4'b0) rdy_viol++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
      $fatal(1, "watchdog expired");
   end

   function automatic item_t mk(input int id, input logic last, input logic [7:0] d);
      item_t it;
      it.id = 2'(id); it.last = last; it.dat = d;
      return it;
   endfunction

   function automatic void build(input item_t q[$], output logic [3:0] v, output logic [31:0] d,
                                 output logic [3:0] l);
      v = '0; d = '0; l = '0;
      foreach (q[k]) begin
         if (!v[q[k].id]) begin
            v[q[k].id] = 1'b1;
            d[{q[k].id, 3'b000} +: 8] = q[k].dat;
            l[q[k].id] = q[k].last;
         end
      end
   endfunction

   task automatic drive_all();
      logic [3:0] v, l;
      logic [31:0] d;
      build(qa, v, d, l);
      ia.req_valid = v; ia.req_data = d; ia.req_last = l;
      build(qb, v, d, l);
      ib.req_valid = v; ib.req_data = d; ib.req_last = l;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_sent(input string tag, input int lane, input int idx,
                             input logic [3:0] g, input logic [7:0] d);
      sent_t s;
      int sz;
      sz = (lane == 0) ? la.size() : lb.size();
      if (idx < sz) begin
         s = (lane == 0) ? la[idx] : lb[idx];
         check(tag, 32'({s.g, s.d}), 32'({g, d}));
      end else begin
         check(tag, 32'hFFFF_FFFF, 32'({g, d}));
      end
   endtask

   // One clock: sample handshakes at negedge, then retire accepted bytes and present the next ones.
   task automatic step();
      logic [3:0] fa, fb;
      int hit;
      @(negedge clk);
      fa = ia.req_valid & ia.req_ready;
      fb = ib.req_valid & ib.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (fa[i]) begin
            hit = -1;
            foreach (qa[k]) if (hit < 0 && qa[k].id == 2'(i)) hit = k;
            if (hit >= 0) qa.delete(hit);
         end
         if (fb[i]) begin
            hit = -1;
            foreach (qb[k]) if (hit < 0 && qb[k].id == 2'(i)) hit = k;
            if (hit >= 0) qb.delete(hit);
         end
      end
      drive_all();
   endtask

   task automatic wait_idle_a(input string tag, input int bound);
      int n;
      n = 0;
      while (!(qa.size() == 0 && ia.grant == 4'b0 && !ia.tx_busy) && n < bound) begin
         step(); n++;
      end
      check(tag, 32'(n < bound), 1);
   endtask

   task automatic wait_idle_b(input string tag, input int bound);
      int n;
      n = 0;
      while (!(qb.size() == 0 && ib.grant == 4'b0 && !ib.tx_busy) && n < bound) begin
         step(); n++;
      end
      check(tag, 32'(n < bound), 1);
   endtask

   initial begin
      int base, ebase, nf, n;

      // Reset state of both arbiters.
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      drive_all();
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant_a", 32'(ia.grant), 0);
      check("rst_ready_a", 32'(ia.req_ready), 0);
      check("rst_send_a", 32'(ia.tx_send), 0);
      check("rst_err_a", 32'(ia.err), 0);
      check("rst_data_a", 32'(ia.tx_data), 0);
      check("rst_grant_b", 32'(ib.grant), 0);
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      step();

      // Two-byte packet from requester 1, with first-byte latency and inter-byte gap.
      base = la.size();
      qa.push_back(mk(1, 1'b0, 8'h41));
      qa.push_back(mk(1, 1'b1, 8'h42));
      drive_all();
      step();
      check("t1_grant", 32'(ia.grant), 'h2);
      check("t1_ready", 32'(ia.req_ready), 'h2);
      step();
      check("t1_send", 32'(ia.tx_send), 1);
      check("t1_data", 32'(ia.tx_data), 'h41);
      wait_idle_a("t1_idle", 2000);
      check_sent("t1_b0", 0, base, 4'b0010, 8'h41);
      check_sent("t1_b1", 0, base + 1, 4'b0010, 8'h42);
      if (la.size() >= base + 2) check("t1_gap", la[base+1].c - la[base].c, 103);
      else check("t1_gap", 32'hFFFF_FFFF, 103);
      check("t1_grant_rel", 32'(ia.grant), 0);
      check("t1_no_err", 32'(err_a.size()), 0);

      // Simultaneous single-byte packets from 0,2,3 after reset; late req0 waits for the wrap.
      rst_n_a = 1'b0;
      step();
      rst_n_a = 1'b1;
      base = la.size();
      qa.push_back(mk(0, 1'b1, 8'h10));
      qa.push_back(mk(2, 1'b1, 8'h20));
      qa.push_back(mk(3, 1'b1, 8'h30));
      drive_all();
      n = 0;
      while (la.size() < base + 2 && n < 1000) begin step(); n++; end
      check("t2_mid", 32'(n < 1000), 1);
      qa.push_back(mk(0, 1'b1, 8'h50));
      drive_all();
      wait_idle_a("t2_idle", 3000);
      check_sent("t2_b0", 0, base, 4'b0001, 8'h10);
      check_sent("t2_b1", 0, base + 1, 4'b0100, 8'h20);
      check_sent("t2_b2", 0, base + 2, 4'b1000, 8'h30);
      check_sent("t2_b3", 0, base + 3, 4'b0001, 8'h50);

      // Three-byte packet from req0 is not interleaved by req1 arriving a cycle later.
      base = la.size();
      qa.push_back(mk(0, 1'b0, 8'hAA));
      qa.push_back(mk(0, 1'b0, 8'hBB));
      qa.push_back(mk(0, 1'b1, 8'hCC));
      drive_all();
      step();
      qa.push_back(mk(1, 1'b1, 8'h77));
      drive_all();
      wait_idle_a("t3_idle", 3000);
      check_sent("t3_b0", 0, base, 4'b0001, 8'hAA);
      check_sent("t3_b1", 0, base + 1, 4'b0001, 8'hBB);
      check_sent("t3_b2", 0, base + 2, 4'b0001, 8'hCC);
      check_sent("t3_b3", 0, base + 3, 4'b0010, 8'h77);

      // Burst limit 2: req0 streams without last, req1 gets a turn between pairs.
      qb.push_back(mk(0, 1'b0, 8'h01));
      qb.push_back(mk(0, 1'b0, 8'h02));
      qb.push_back(mk(0, 1'b0, 8'h03));
      qb.push_back(mk(0, 1'b0, 8'h04));
      qb.push_back(mk(1, 1'b1, 8'hE1));
      drive_all();
      wait_idle_b("t4_idle", 4000);
      check_sent("t4_b0", 1, 0, 4'b0001, 8'h01);
      check_sent("t4_b1", 1, 1, 4'b0001, 8'h02);
      check_sent("t4_b2", 1, 2, 4'b0010, 8'hE1);
      check_sent("t4_b3", 1, 3, 4'b0001, 8'h03);
      check_sent("t4_b4", 1, 4, 4'b0001, 8'h04);
      check("t4_count", 32'(lb.size()), 5);
      check("t4_no_err", 32'(err_b.size()), 0);

      // Busy never rises: one err pulse per byte, TIMEOUT+1 cycles after each send.
      busy_en_a = 1'b0;
      base = la.size();
      ebase = err_a.size();
      qa.push_back(mk(2, 1'b0, 8'h5A));
      qa.push_back(mk(2, 1'b1, 8'h5B));
      drive_all();
      wait_idle_a("t5_idle", 500);
      check("t5_err_cnt", 32'(err_a.size() - ebase), 2);
      check_sent("t5_b0", 0, base, 4'b0100, 8'h5A);
      check_sent("t5_b1", 0, base + 1, 4'b0100, 8'h5B);
      if (la.size() >= base + 2 && err_a.size() >= ebase + 2) begin
         check("t5_err0_lat", 32'(err_a[ebase]) - la[base].c, 16);
         check("t5_resume", la[base+1].c - 32'(err_a[ebase]), 2);
         check("t5_err1_lat", 32'(err_a[ebase+1]) - la[base+1].c, 16);
      end else begin
         check("t5_timing", 32'hFFFF_FFFF, 16);
      end
      busy_en_a = 1'b1;

      // Reset during WAIT_LO: grant clears, next send waits for busy to fall, req0 goes first.
      base = la.size();
      qa.push_back(mk(1, 1'b0, 8'h61));
      qa.push_back(mk(1, 1'b1, 8'h62));
      drive_all();
      n = 0;
      while (!ia.tx_busy && n < 200) begin step(); n++; end
      check("t6_busy_rise", 32'(n < 200), 1);
      repeat (5) step();
      rst_n_a = 1'b0;
      qa.delete();
      for (int i = 0; i < N; i++) qa.push_back(mk(i, 1'b1, 8'hA0 + 8'(i)));
      drive_all();
      nf = fall_a.size();
      @(negedge clk);
      check("t6_rst_ready", 32'(ia.req_ready), 0);
      check("t6_rst_send", 32'(ia.tx_send), 0);
      @(posedge clk);
      #1;
      rst_n_a = 1'b1;
      check("t6_grant_clr", 32'(ia.grant), 0);
      wait_idle_a("t6_idle", 5000);
      check_sent("t6_pre", 0, base, 4'b0010, 8'h61);
      check_sent("t6_b0", 0, base + 1, 4'b0001, 8'hA0);
      check_sent("t6_b1", 0, base + 2, 4'b0010, 8'hA1);
      check_sent("t6_b2", 0, base + 3, 4'b0100, 8'hA2);
      check_sent("t6_b3", 0, base + 4, 4'b1000, 8'hA3);
      if (la.size() >= base + 2 && fall_a.size() > nf)
         check("t6_after_fall", la[base+1].c - 32'(fall_a[nf]), 2);
      else
         check("t6_after_fall", 32'hFFFF_FFFF, 2);

      // Global invariants collected over the whole run.
      check("send_while_busy", 32'(send_busy_viol), 0);
      check("ready_not_owner", 32'(rdy_viol), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
